// File: rtl/motor_pkg.sv
// motor_pkg: ramp controller state encoding and default parameter values
package motor_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_BRAKE, ST_DEAD} state_t;
    localparam int DEF_COUNTER_WIDTH   = 16;
    localparam int DEF_STEP            = 500;
    localparam int DEF_TICK_CYCLES     = 50000;
    localparam int DEF_DEADTIME_CYCLES = 100000;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick on terminal count
module tick_gen import motor_pkg::*; #(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = cnt_q == CW'(TICK_CYCLES - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: ramped speed/direction control with brake and dead-time
module motor_ramp_ctrl import motor_pkg::*; #(
    parameter int COUNTER_WIDTH   = DEF_COUNTER_WIDTH,
    parameter int STEP            = DEF_STEP,
    parameter int TICK_CYCLES     = DEF_TICK_CYCLES,
    parameter int DEADTIME_CYCLES = DEF_DEADTIME_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic                     cmd_dir,
    input  logic [COUNTER_WIDTH-1:0] cmd_speed,
    input  logic                     estop,
    output logic                     dir,
    output logic [COUNTER_WIDTH-1:0] speed,
    output logic                     reversing,
    output logic                     at_target
);
    localparam int W  = COUNTER_WIDTH;
    localparam int DW = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME_CYCLES - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   speed_q, speed_d, tspeed_q, tspeed_d;
    logic           dir_q, dir_d, tdir_q, tdir_d;
    logic [DW-1:0]  dead_q, dead_d;
    logic           tick;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    // one bit of headroom so neither the add nor the subtract can wrap
    function automatic logic [W-1:0] ramp(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic [W:0] up, dn;
        up = {1'b0, cur} + (W+1)'(STEP);
        dn = {1'b0, cur} - (W+1)'(STEP);
        return (cur < tgt) ? ((up > {1'b0, tgt}) ? tgt : up[W-1:0])
                           : ((dn[W] || dn[W-1:0] < tgt) ? tgt : dn[W-1:0]);
    endfunction

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        dir_d    = dir_q;
        tspeed_d = tspeed_q;
        tdir_d   = tdir_q;
        dead_d   = dead_q;
        if (estop) begin
            speed_d  = '0;
            tspeed_d = '0;
            state_d  = ST_DEAD;
            dead_d   = DEAD_LOAD;
        end else begin
            if (cmd_valid) begin
                tspeed_d = cmd_speed;
                tdir_d   = (cmd_speed != '0) ? cmd_dir : tdir_q;
            end
            case (state_q)
                ST_RUN: begin
                    if (tdir_q != dir_q) state_d = ST_BRAKE;
                    else if (tick)       speed_d = ramp(speed_q, tspeed_q);
                end
                ST_BRAKE: begin
                    if (tdir_q == dir_q) begin
                        state_d = ST_RUN;
                        speed_d = tick ? ramp(speed_q, tspeed_q) : speed_q;
                    end else if (speed_q == '0) begin
                        state_d = ST_DEAD;
                        dead_d  = DEAD_LOAD;
                    end else if (tick) begin
                        speed_d = ramp(speed_q, '0);
                    end
                end
                ST_DEAD: begin
                    if (dead_q == '0) begin
                        dir_d   = tdir_q;
                        state_d = ST_RUN;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            speed_q  <= '0;
            dir_q    <= 1'b0;
            tspeed_q <= '0;
            tdir_q   <= 1'b0;
            dead_q   <= '0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            dir_q    <= dir_d;
            tspeed_q <= tspeed_d;
            tdir_q   <= tdir_d;
            dead_q   <= dead_d;
        end
    end

    assign dir       = dir_q;
    assign speed     = speed_q;
    assign reversing = state_q != ST_RUN;
    assign at_target = (state_q == ST_RUN) && (speed_q == tspeed_q);
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: scoreboard bench with directed scenarios and random traffic
module tb_motor_ramp_ctrl;
    localparam int W = 16, STEP = 100, TICK = 4, DEAD = 8;

    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_dir = 1'b0, estop = 1'b0;
    logic [W-1:0] cmd_speed = '0;
    logic dir, reversing, at_target;
    logic [W-1:0] speed;

    always #5 clk = ~clk;

    motor_ramp_ctrl #(.COUNTER_WIDTH(W), .STEP(STEP), .TICK_CYCLES(TICK), .DEADTIME_CYCLES(DEAD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_speed(cmd_speed),
        .estop(estop), .dir(dir), .speed(speed), .reversing(reversing), .at_target(at_target)
    );

    int n_pass = 0, n_total = 0;
    logic [W+2:0] exp_q[$];
    int seen[$];
    int last_speed = -1;
    logic last_dir = 1'b0;
    bit rev_seen = 0;
    int dir_changes = 0;
    logic [W-1:0] obs_speed = '0;
    logic obs_dir = 1'b0, obs_rev = 1'b0, obs_at = 1'b0;
    string scen = "reset";

    int m_speed, m_ts, m_dead, m_cyc;
    bit m_dir, m_td, m_brake;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, expv);
    endtask

    task automatic check_seq(input string name, input int q[$]);
        check({name, "_len"}, seen.size(), q.size());
        for (int i = 0; i < q.size() && i < seen.size(); i++)
            check($sformatf("%s[%0d]", name, i), seen[i], q[i]);
    endtask

    function automatic int approach(input int s, input int t);
        int d;
        d = t - s;
        if (d > STEP) d = STEP;
        if (d < -STEP) d = -STEP;
        return s + d;
    endfunction

    // reference: speed closes on its goal by at most STEP per tick; a direction change
    // means brake to zero, sit DEAD clocks, then adopt the new direction
    task automatic model_step(input bit r, input bit e, input bit v, input bit d, input int s);
        bit tick;
        int ots;
        bit otd;
        if (r) begin
            m_speed = 0; m_dir = 0; m_ts = 0; m_td = 0; m_dead = -1; m_brake = 0; m_cyc = 0;
            return;
        end
        tick = (m_cyc % TICK) == TICK - 1;
        m_cyc++;
        ots = m_ts;
        otd = m_td;
        if (e) begin
            m_speed = 0; m_ts = 0; m_dead = DEAD - 1; m_brake = 0;
            return;
        end
        if (v) begin
            m_ts = s;
            if (s != 0) m_td = d;
        end
        if (m_dead >= 0) begin
            if (m_dead == 0) begin m_dir = otd; m_dead = -1; end
            else m_dead--;
        end else if (otd != m_dir) begin
            if (!m_brake) m_brake = 1;
            else if (m_speed == 0) begin m_brake = 0; m_dead = DEAD - 1; end
            else if (tick) m_speed = approach(m_speed, 0);
        end else begin
            m_brake = 0;
            if (tick) m_speed = approach(m_speed, ots);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic v, input logic d, input logic [W-1:0] s);
        bit rev;
        @(negedge clk);
        rst = r; estop = e; cmd_valid = v; cmd_dir = d; cmd_speed = s;
        model_step(r, e, v, d, int'(s));
        rev = m_brake || (m_dead >= 0);
        exp_q.push_back({m_dir, W'(m_speed), rev, !rev && (m_speed == m_ts)});
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, '0);
    endtask

    task automatic start(input string s);
        scen = s;
        seen.delete();
        rev_seen = 0;
        dir_changes = 0;
    endtask

    initial begin : monitor
        logic [W+2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_total++;
                if ({dir, speed, reversing, at_target} === e) n_pass++;
                else $display("FAIL %s: dir/speed/rev/at got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                              scen, dir, speed, reversing, at_target, e[W+2], e[W+1:2], e[1], e[0]);
                n_total++;
                if (dir !== last_dir && speed !== '0)
                    $display("FAIL %s dir_flip: speed %0d while dir changed, required 0", scen, speed);
                else n_pass++;
                if (int'(speed) != last_speed) seen.push_back(int'(speed));
                if (dir !== last_dir) dir_changes++;
                if (reversing) rev_seen = 1;
                last_speed = int'(speed);
                last_dir = dir;
                obs_speed = speed; obs_dir = dir; obs_rev = reversing; obs_at = at_target;
            end
        end
    end

    initial begin
        int q[$];
        bit found;
        logic r, e, v, d;
        logic [W-1:0] s;
        int sel;

        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        idle(2);
        check("rst_speed", obs_speed, 0);
        check("rst_dir", obs_dir, 0);
        check("rst_rev", obs_rev, 0);
        check("rst_at", obs_at, 1);

        start("ramp_up");
        cyc(0, 0, 1, 0, 350);
        idle(24);
        q = {100, 200, 300, 350};
        check_seq("ramp_up", q);
        check("ramp_up_at", obs_at, 1);

        start("reverse");
        cyc(0, 0, 1, 1, 200);
        idle(45);
        q = {250, 150, 50, 0, 100, 200};
        check_seq("reverse", q);
        check("reverse_rev_seen", rev_seen, 1);
        check("reverse_dir", obs_dir, 1);
        check("reverse_dir_changes", dir_changes, 1);
        check("reverse_at", obs_at, 1);

        start("brake_setup");
        cyc(1, 0, 0, 0, '0);
        idle(1);
        cyc(0, 0, 1, 0, 350);
        idle(24);
        cyc(0, 0, 1, 1, 200);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle(1);
            found = (obs_speed == 150) && obs_rev;
        end
        check("brake_reach_150", found, 1);
        start("brake_revert");
        cyc(0, 0, 1, 0, 300);
        idle(16);
        q = {250, 300};
        check_seq("brake_revert", q);
        check("brake_revert_dir_changes", dir_changes, 0);
        check("brake_revert_dir", obs_dir, 0);
        check("brake_revert_rev", obs_rev, 0);

        start("estop");
        repeat (3) cyc(0, 1, 1, 1, 500);
        idle(20);
        check("estop_speed", obs_speed, 0);
        check("estop_dir", obs_dir, 0);
        check("estop_at", obs_at, 1);
        q = {0};
        check_seq("estop_hold", q);
        cyc(0, 0, 1, 0, 200);
        idle(12);
        q = {0, 100, 200};
        check_seq("estop_resume", q);

        start("zero_cmd");
        cyc(0, 0, 1, 1, 0);
        idle(12);
        q = {100, 0};
        check_seq("zero_cmd", q);
        check("zero_cmd_rev_seen", rev_seen, 0);
        check("zero_cmd_dir", obs_dir, 0);

        start("rst_dead");
        cyc(0, 0, 1, 1, 100);
        idle(4);
        check("rst_dead_in_dead", obs_rev, 1);
        cyc(1, 0, 0, 0, '0);
        idle(1);
        check("rst_dead_speed", obs_speed, 0);
        check("rst_dead_dir", obs_dir, 0);
        check("rst_dead_rev", obs_rev, 0);
        check("rst_dead_at", obs_at, 1);
        idle(20);
        check("rst_dead_later_dir", obs_dir, 0);
        check("rst_dead_later_speed", obs_speed, 0);

        start("random");
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 299) == 0;
            e = $urandom_range(0, 59) == 0;
            v = $urandom_range(0, 9) == 0;
            d = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            s = (sel == 0) ? W'(0) : (sel == 1) ? W'(65535) :
                (sel == 2) ? W'(65535 - $urandom_range(0, 150)) : W'($urandom_range(0, 1500));
            cyc(r, e, v, d, s);
            if (seen.size() > 64) seen.delete();
        end

        idle(2);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
